// File: rtl/fios_bram_sequencer.sv
// Operand/result mover between BRAM port B and the FIOS Montgomery core.
// Optional core watchdog enabled by defining FIOS_SEQ_TIMEOUT_EN.
module fios_bram_sequencer #(
  parameter int WIDTH          = 256,
  localparam int S             = (WIDTH + 1) / 17 + 1,
  parameter int BRAM_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [31:0]       bram_addr_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [31:0]       bram_din_o,
  input  logic [31:0]       bram_dout_i,
  output logic [S*17-1:0]   n_o,
  output logic [S*17-1:0]   x_o,
  output logic [S*17-1:0]   y_o,
  output logic [16:0]       n_prime_0_o,
  output logic              core_start_o,
  input  logic              core_done_i,
  input  logic [S*17-1:0]   core_res_i
);

  localparam int NWORDS = 3 * S + 1;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int WR_W   = $clog2(S);
  localparam logic [IDX_W-1:0] LAST_RD    = IDX_W'(NWORDS - 1);
  localparam logic [WR_W-1:0]  LAST_WR    = WR_W'(S - 1);
  localparam logic [1:0]       LAST_DRAIN = 2'(BRAM_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [WR_W-1:0]   wr_idx_q;
  logic [1:0]        drain_q;
  logic [16:0]       words_q [NWORDS];
  logic [S*17-1:0]   res_q;
  logic              pipe_vld_q [1:BRAM_LATENCY];
  logic [IDX_W-1:0]  pipe_idx_q [1:BRAM_LATENCY];
  logic              unused_ok;

  assign unused_ok = ^{bram_dout_i[31:17], (TIMEOUT_CYCLES != 0)};

`ifdef FIOS_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt_q;
  logic            timeout;
  logic            error_q;

  assign timeout = (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign error_o = error_q;

  // Error stays sticky until the next accepted start clears it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
      if (state_q == ST_IDLE && start_i)
        error_q <= 1'b0;
      else if (state_q == ST_WAIT && !core_done_i && timeout)
        error_q <= 1'b1;
    end
  end
`else
  assign error_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_READ;
      ST_READ:  if (rd_idx_q == LAST_RD) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == LAST_DRAIN) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done_i) state_d = ST_WRITE;
`ifdef FIOS_SEQ_TIMEOUT_EN
        else if (timeout) state_d = ST_DONE;
`endif
      end
      ST_WRITE: if (wr_idx_q == LAST_WR) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      drain_q  <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= (state_q == ST_READ)  ? rd_idx_q + 1'b1 : '0;
      wr_idx_q <= (state_q == ST_WRITE) ? wr_idx_q + 1'b1 : '0;
      drain_q  <= (state_q == ST_DRAIN) ? drain_q + 1'b1  : '0;
      if (state_q == ST_WAIT && core_done_i)
        res_q <= core_res_i;
    end
  end

  // Each read's word index rides alongside the BRAM latency so the
  // returning data lands in the right limb; reset drops anything in flight.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int j = 1; j <= BRAM_LATENCY; j++) begin
        pipe_vld_q[j] <= 1'b0;
        pipe_idx_q[j] <= '0;
      end
      for (int i = 0; i < NWORDS; i++)
        words_q[i] <= '0;
    end else begin
      pipe_vld_q[1] <= (state_q == ST_READ);
      pipe_idx_q[1] <= rd_idx_q;
      for (int j = 2; j <= BRAM_LATENCY; j++) begin
        pipe_vld_q[j] <= pipe_vld_q[j-1];
        pipe_idx_q[j] <= pipe_idx_q[j-1];
      end
      if (pipe_vld_q[BRAM_LATENCY])
        words_q[pipe_idx_q[BRAM_LATENCY]] <= bram_dout_i[16:0];
    end
  end

  always_comb begin
    busy_o       = (state_q != ST_IDLE);
    done_o       = (state_q == ST_DONE);
    core_start_o = (state_q == ST_START);
    bram_en_o    = 1'b0;
    bram_we_o    = 4'h0;
    bram_addr_o  = '0;
    bram_din_o   = '0;
    if (state_q == ST_READ) begin
      bram_en_o   = 1'b1;
      bram_addr_o = 32'({rd_idx_q, 2'b00});
    end else if (state_q == ST_WRITE) begin
      bram_en_o   = 1'b1;
      bram_we_o   = 4'hf;
      bram_addr_o = 32'({wr_idx_q, 2'b00});
      bram_din_o  = {15'b0, res_q[17*wr_idx_q +: 17]};
    end
  end

  // Word map: n at 0..S-1, n' at S, X at S+1..2S, Y at 2S+1..3S.
  for (genvar i = 0; i < S; i++) begin : g_limbs
    assign n_o[17*i +: 17] = words_q[i];
    assign x_o[17*i +: 17] = words_q[S + 1 + i];
    assign y_o[17*i +: 17] = words_q[2*S + 1 + i];
  end
  assign n_prime_0_o = words_q[S];

endmodule

// File: tb/tb_fios_bram_sequencer.sv
// Directed bench for fios_bram_sequencer with a 2-cycle-latency BRAM model.
module tb_fios_bram_sequencer;

  localparam int S = 16;
  localparam int W = 17 * S;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [31:0]   bram_addr;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout = '0;
  logic [W-1:0]  n_o, x_o, y_o;
  logic [16:0]   np0;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [W-1:0]  core_res = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];
  logic [31:0] rd1 = '0;
  int          wr_count = 0;

  fios_bram_sequencer dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .bram_addr_o  (bram_addr),
    .bram_en_o    (bram_en),
    .bram_we_o    (bram_we),
    .bram_din_o   (bram_din),
    .bram_dout_i  (bram_dout),
    .n_o          (n_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .n_prime_0_o  (np0),
    .core_start_o (core_start),
    .core_done_i  (core_done),
    .core_res_i   (core_res)
  );

  always #5 clock = ~clock;

  // BRAM model: word k reloads with k+1 whenever reset is high; two-stage read.
  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'(k + 1);
    end else if (bram_en && bram_we == 4'hf) begin
      mem[bram_addr[7:2]] <= bram_din;
      wr_count <= wr_count + 1;
    end
    rd1       <= mem[bram_addr[7:2]];
    bram_dout <= rd1;
  end

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      vectors++;
      if (bram_en !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold c%0d: en=%b busy=%b, expected 0 0", c, bram_en, busy);
      end
    end
    vectors++;
    if ({done, error, core_start, bram_we} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: done/err/cs/we=%b, expected 0", {done, error, core_start, bram_we});
    end
    vectors++;
    if (bram_addr !== 32'h0 || bram_din !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: addr=%h din=%h, expected 0 0", bram_addr, bram_din);
    end
    vectors++;
    if (n_o !== '0 || x_o !== '0 || y_o !== '0 || np0 !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_operands: np0=%h, expected all operands 0", np0);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || bram_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: busy=%b en=%b, expected 0 0", busy, bram_en);
    end
  endtask

  task automatic test_read_sequence();
    start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clock);
      start = 1'b0;
      vectors++;
      if (bram_en !== (c <= 49) || bram_we !== 4'h0 || busy !== 1'b1
          || core_start !== (c == 52)) begin
        miscompares++;
        $display("[TB] FAIL read_ctrl c%0d: en=%b we=%h busy=%b cs=%b, expected %b 0 1 %b",
                 c, bram_en, bram_we, busy, core_start, (c <= 49), (c == 52));
      end
      if (c <= 49) begin
        vectors++;
        if (bram_addr !== 32'((c - 1) * 4)) begin
          miscompares++;
          $display("[TB] FAIL read_addr c%0d: got %h, expected %h", c, bram_addr, 32'((c - 1) * 4));
        end
      end
    end
    for (int i = 0; i < S; i++) begin
      vectors++;
      if (n_o[17*i +: 17] !== 17'(i + 1) || x_o[17*i +: 17] !== 17'(S + 2 + i)
          || y_o[17*i +: 17] !== 17'(2*S + 2 + i)) begin
        miscompares++;
        $display("[TB] FAIL operand_limb %0d: n=%0d x=%0d y=%0d, expected %0d %0d %0d",
                 i, n_o[17*i +: 17], x_o[17*i +: 17], y_o[17*i +: 17], i + 1, S + 2 + i, 2*S + 2 + i);
      end
    end
    vectors++;
    if (np0 !== 17'd17) begin
      miscompares++;
      $display("[TB] FAIL n_prime_0: got %0d, expected 17", np0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      vectors++;
      if (core_start !== 1'b0 || busy !== 1'b1 || bram_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wait_hold: cs=%b busy=%b en=%b, expected 0 1 0", core_start, busy, bram_en);
      end
    end
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_count;
    core_res  = {S{17'h1FFFF}};
    core_done = 1'b1;
    for (int i = 0; i < S; i++) begin
      @(negedge clock);
      core_done = 1'b0;
      core_res  = '0;
      vectors++;
      if (bram_en !== 1'b1 || bram_we !== 4'hf || bram_addr !== 32'(i * 4)
          || bram_din !== 32'h0001FFFF || done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL write %0d: en=%b we=%h addr=%h din=%h done=%b, expected 1 f %h 0001ffff 0",
                 i, bram_en, bram_we, bram_addr, bram_din, done, 32'(i * 4));
      end
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b1 || bram_en !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_cycle: done=%b en=%b busy=%b err=%b, expected 1 0 1 0", done, bram_en, busy, error);
    end
    vectors++;
    if (wr_count - w0 !== 16 || mem[0] !== 32'h1FFFF || mem[15] !== 32'h1FFFF || mem[16] !== 32'd17) begin
      miscompares++;
      $display("[TB] FAIL write_mem: writes=%0d m0=%h m15=%h m16=%h, expected 16 1ffff 1ffff 11",
               wr_count - w0, mem[0], mem[15], mem[16]);
    end
    vectors++;
    if (n_o[16:0] !== 17'd1 || y_o[17*15 +: 17] !== 17'd49) begin
      miscompares++;
      $display("[TB] FAIL operand_hold: n0=%0d y15=%0d, expected 1 49", n_o[16:0], y_o[17*15 +: 17]);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL back_idle: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int starts = 0, dones = 0, start_cyc = 0, done_cyc = 0, late_busy = 0;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      start     = (c == 10 || c == 60);
      core_done = (c == 70);
      core_res  = (c == 70) ? {S{17'h00AAA}} : '0;
      if (core_start === 1'b1) begin starts++; start_cyc = c; end
      if (done === 1'b1) begin dones++; done_cyc = c; end
      if (c >= 88 && (busy !== 1'b0 || bram_en !== 1'b0)) late_busy++;
      if (c == 52) begin
        vectors++;
        if (n_o[16:0] !== 17'h1FFFF) begin
          miscompares++;
          $display("[TB] FAIL reread_n0: got %h, expected 1ffff", n_o[16:0]);
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (starts !== 1 || start_cyc !== 52) begin
      miscompares++;
      $display("[TB] FAIL b2b_core_start: count=%0d cycle=%0d, expected 1 52", starts, start_cyc);
    end
    vectors++;
    if (dones !== 1 || done_cyc !== 87) begin
      miscompares++;
      $display("[TB] FAIL b2b_done: count=%0d cycle=%0d, expected 1 87", dones, done_cyc);
    end
    vectors++;
    if (late_busy !== 0 || mem[3] !== 32'h00AAA) begin
      miscompares++;
      $display("[TB] FAIL b2b_ignored_start: late_busy=%0d m3=%h, expected 0 00000aaa", late_busy, mem[3]);
    end
  endtask

  task automatic test_reset_mid();
    int starts = 0, dones = 0, done_cyc = 0, w0, stray = 0;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    vectors++;
    if (bram_en !== 1'b1 || bram_addr !== 32'h24) begin
      miscompares++;
      $display("[TB] FAIL mid_read: en=%b addr=%h, expected 1 24", bram_en, bram_addr);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if (bram_en !== 1'b0 || busy !== 1'b0 || n_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: en=%b busy=%b n0=%h, expected 0 0 0", bram_en, busy, n_o[16:0]);
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (core_start !== 1'b0 || bram_en !== 1'b0 || busy !== 1'b0) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_quiet: active cycles=%0d, expected 0", stray);
    end
    w0 = wr_count;
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      start     = 1'b0;
      core_done = (c == 55);
      for (int i = 0; i < S; i++)
        core_res[17*i +: 17] = (c == 55) ? 17'(3 * i + 5) : 17'h0;
      if (core_start === 1'b1) begin
        starts++;
        vectors++;
        if (c !== 52 || n_o[17*5 +: 17] !== 17'd6) begin
          miscompares++;
          $display("[TB] FAIL rerun_start: cycle=%0d n5=%0d, expected 52 6", c, n_o[17*5 +: 17]);
        end
      end
      if (done === 1'b1) begin dones++; done_cyc = c; end
    end
    core_done = 1'b0;
    vectors++;
    if (starts !== 1 || dones !== 1 || done_cyc !== 72) begin
      miscompares++;
      $display("[TB] FAIL rerun_done: starts=%0d dones=%0d cycle=%0d, expected 1 1 72", starts, dones, done_cyc);
    end
    vectors++;
    if (wr_count - w0 !== 16 || mem[0] !== 32'd5 || mem[7] !== 32'd26 || mem[15] !== 32'd50) begin
      miscompares++;
      $display("[TB] FAIL rerun_mem: writes=%0d m0=%0d m7=%0d m15=%0d, expected 16 5 26 50",
               wr_count - w0, mem[0], mem[7], mem[15]);
    end
  endtask

  initial begin
    test_reset();
    test_read_sequence();
    test_write();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
